// File: rtl/control_edicion_botones.sv
// control_edicion_botones: synchronizes and debounces the five clock-setting
// push-buttons, runs the IDLE/EDIT state machine and generates the field
// select plus single-cycle up/down strobes (with auto-repeat) for the BCD
// counters downstream.
module control_edicion_botones #(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 25_000_000,
  parameter int N_FIELDS      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_edit,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       edit_mode
);

  localparam int DW      = $clog2(DEB_CYCLES + 1);
  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW      = $clog2(RPT_MAX + 1);

  localparam int B_EDIT  = 0;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 3;
  localparam int B_RIGHT = 4;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_LAST  = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] RPT_SAT    = RW'(RPT_MAX);
  localparam logic [3:0]    LAST_FIELD = 4'(N_FIELDS);

  typedef enum logic {IDLE, EDIT} state_t;

  logic [4:0]    raw_btn;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    stable;
  logic [4:0]    held;
  logic [4:0]    press;
  logic [DW-1:0] deb_cnt [5];

  state_t        state;
  logic [3:0]    field;
  logic [3:0]    field_next;
  logic [RW-1:0] rpt_timer;
  logic          rpt_first;
  logic          rpt_active;
  logic          both_d;

  logic          up_h;
  logic          dn_h;
  logic          one_held;
  logic          both_now;
  logic          new_seq;
  logic          field_evt;
  logic [RW-1:0] rpt_last;
  logic          rpt_fire;

  assign raw_btn = {btn_right, btn_left, btn_down, btn_up, btn_edit};

  // Two-flop synchronizer bringing every raw button into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
    end
  end

  // Debounce: a level change is accepted only after DEB_CYCLES consecutive
  // disagreeing cycles; the flip happens on the cycle the count would reach
  // DEB_CYCLES, so the counter never exceeds DEB_CYCLES-1
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] >= DEB_LAST) begin
          stable[i]  <= ~stable[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Rising-edge detect of the stable levels; held is aligned with press
  always_ff @(posedge clk) begin
    if (reset) begin
      held  <= '0;
      press <= '0;
    end else begin
      press <= stable & ~held;
      held  <= stable;
    end
  end

  assign up_h      = held[B_UP];
  assign dn_h      = held[B_DOWN];
  assign one_held  = up_h ^ dn_h;
  assign both_now  = up_h & dn_h;
  assign new_seq   = one_held & (press[B_UP] | press[B_DOWN] | both_d);
  assign field_evt = press[B_LEFT] ^ press[B_RIGHT];
  assign rpt_last  = rpt_first ? HOLD_LAST : REP_LAST;
  assign rpt_fire  = rpt_active & one_held & (rpt_timer == rpt_last);

  // Next field with wrap-around; simultaneous left+right leaves it unchanged
  always_comb begin
    field_next = field;
    if (press[B_RIGHT] && !press[B_LEFT]) begin
      field_next = (field >= LAST_FIELD) ? 4'd1 : field + 4'd1;
    end else if (press[B_LEFT] && !press[B_RIGHT]) begin
      field_next = (field <= 4'd1) ? LAST_FIELD : field - 4'd1;
    end
  end

  // Edit FSM with registered outputs; priority is edit > field change > up/down
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      field      <= 4'd1;
      en_count   <= 4'd0;
      edit_mode  <= 1'b0;
      enUP       <= 1'b0;
      enDOWN     <= 1'b0;
      rpt_timer  <= '0;
      rpt_first  <= 1'b1;
      rpt_active <= 1'b0;
      both_d     <= 1'b0;
    end else begin
      enUP   <= 1'b0;
      enDOWN <= 1'b0;
      both_d <= both_now;
      case (state)
        IDLE: begin
          edit_mode  <= 1'b0;
          en_count   <= 4'd0;
          rpt_timer  <= '0;
          rpt_first  <= 1'b1;
          rpt_active <= 1'b0;
          if (press[B_EDIT]) begin
            state     <= EDIT;
            field     <= 4'd1;
            en_count  <= 4'd1;
            edit_mode <= 1'b1;
          end
        end
        EDIT: begin
          if (press[B_EDIT]) begin
            state      <= IDLE;
            en_count   <= 4'd0;
            edit_mode  <= 1'b0;
            rpt_timer  <= '0;
            rpt_first  <= 1'b1;
            rpt_active <= 1'b0;
          end else if (field_evt) begin
            field      <= field_next;
            en_count   <= field_next;
            rpt_timer  <= '0;
            rpt_first  <= 1'b1;
            rpt_active <= (rpt_active | new_seq) & one_held;
          end else if (!one_held) begin
            rpt_timer  <= '0;
            rpt_first  <= 1'b1;
            rpt_active <= 1'b0;
          end else if (new_seq) begin
            enUP       <= up_h;
            enDOWN     <= dn_h;
            rpt_timer  <= '0;
            rpt_first  <= 1'b1;
            rpt_active <= 1'b1;
          end else if (rpt_fire) begin
            enUP      <= up_h;
            enDOWN    <= dn_h;
            rpt_timer <= '0;
            rpt_first <= 1'b0;
          end else if (rpt_active && (rpt_timer < RPT_SAT)) begin
            rpt_timer <= rpt_timer + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_edicion_botones.sv
// tb_control_edicion_botones: directed scenarios for the button conditioning
// and edit-control block, with small debounce/hold/repeat parameters.
module tb_control_edicion_botones;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int NF   = 3;
  localparam int LAT  = DEB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn = '0;
  logic [3:0] en_count;
  logic       enUP;
  logic       enDOWN;
  logic       edit_mode;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int overlap = 0;

  int         up_q[$];
  int         dn_q[$];
  int         em_cyc[$];
  logic       em_val[$];
  int         ec_cyc[$];
  logic [3:0] ec_val[$];
  logic       em_prev = 1'b0;
  logic [3:0] ec_prev = 4'd0;

  control_edicion_botones #(
    .DEB_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP),
    .N_FIELDS(NF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_edit(btn[0]),
    .btn_up(btn[1]),
    .btn_down(btn[2]),
    .btn_left(btn[3]),
    .btn_right(btn[4]),
    .en_count(en_count),
    .enUP(enUP),
    .enDOWN(enDOWN),
    .edit_mode(edit_mode)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of the last rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Log strobe cycles and output changes, sampled away from the active edge
  always @(negedge clk) begin
    if (enUP === 1'b1) up_q.push_back(cyc);
    if (enDOWN === 1'b1) dn_q.push_back(cyc);
    if (enUP === 1'b1 && enDOWN === 1'b1) overlap++;
    if (edit_mode !== em_prev) begin
      em_cyc.push_back(cyc);
      em_val.push_back(edit_mode);
      em_prev = edit_mode;
    end
    if (en_count !== ec_prev) begin
      ec_cyc.push_back(cyc);
      ec_val.push_back(en_count);
      ec_prev = en_count;
    end
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_logs();
    up_q.delete();
    dn_q.delete();
    em_cyc.delete();
    em_val.delete();
    ec_cyc.delete();
    ec_val.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise one raw button for len sampled edges; t is the first sampling edge
  task automatic hold_btn(input int idx, input int len, output int t);
    @(negedge clk);
    btn[idx] = 1'b1;
    t = cyc + 1;
    repeat (len) @(negedge clk);
    btn[idx] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (en_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_en_count: got %0d expected 0", en_count);
    end
    tests_run++;
    if (edit_mode !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_edit_mode: got %0b expected 0", edit_mode);
    end
    tests_run++;
    if (enUP !== 1'b0 || enDOWN !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got up=%0b down=%0b expected 0 0", enUP, enDOWN);
    end
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_edit_toggle();
    int t;
    int got;
    clear_logs();
    hold_btn(0, 10, t);
    wait_cycles(10);
    tests_run++;
    if (em_cyc.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL edit_enter_changes: got %0d expected 1", em_cyc.size());
    end
    got = (em_cyc.size() > 0) ? em_cyc[0] : -1;
    tests_run++;
    if (got != t + LAT) begin
      tests_failed++;
      $display("[TB] FAIL edit_enter_latency: got edge %0d expected %0d", got, t + LAT);
    end
    got = (ec_cyc.size() > 0) ? ec_cyc[0] : -1;
    tests_run++;
    if (got != t + LAT || en_count !== 4'd1 || edit_mode !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL edit_enter_field: got edge %0d field %0d mode %0b expected edge %0d field 1 mode 1",
               got, en_count, edit_mode, t + LAT);
    end
    clear_logs();
    hold_btn(0, 10, t);
    wait_cycles(10);
    got = (em_cyc.size() > 0) ? em_cyc[0] : -1;
    tests_run++;
    if (got != t + LAT || edit_mode !== 1'b0 || en_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL edit_exit: got edge %0d mode %0b field %0d expected edge %0d mode 0 field 0",
               got, edit_mode, en_count, t + LAT);
    end
  endtask

  task automatic test_glitch_up();
    int t;
    int got;
    hold_btn(0, 6, t);
    wait_cycles(12);
    tests_run++;
    if (edit_mode !== 1'b1 || en_count !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL glitch_enter_edit: got mode %0b field %0d expected 1 1", edit_mode, en_count);
    end
    clear_logs();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      btn[1] = ((k / 2) % 2) == 0;
    end
    hold_btn(1, 6, t);
    wait_cycles(30);
    tests_run++;
    if (up_q.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL glitch_up_count: got %0d pulses expected 1", up_q.size());
    end
    got = (up_q.size() > 0) ? up_q[0] : -1;
    tests_run++;
    if (got != t + LAT) begin
      tests_failed++;
      $display("[TB] FAIL glitch_up_latency: got edge %0d expected %0d", got, t + LAT);
    end
    tests_run++;
    if (dn_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_no_down: got %0d pulses expected 0", dn_q.size());
    end
  endtask

  task automatic test_field_nav();
    int t;
    int exp_r[3] = '{2, 3, 1};
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      hold_btn(4, 6, t);
      wait_cycles(12);
      tests_run++;
      if (en_count !== 4'(exp_r[i])) begin
        tests_failed++;
        $display("[TB] FAIL field_right_%0d: got %0d expected %0d", i, en_count, exp_r[i]);
      end
    end
    hold_btn(3, 6, t);
    wait_cycles(12);
    tests_run++;
    if (en_count !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL field_left_wrap: got %0d expected 3", en_count);
    end
    @(negedge clk);
    btn[3] = 1'b1;
    btn[4] = 1'b1;
    wait_cycles(6);
    btn[3] = 1'b0;
    btn[4] = 1'b0;
    wait_cycles(12);
    tests_run++;
    if (en_count !== 4'd3 || edit_mode !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL field_left_right: got field %0d mode %0b expected 3 1", en_count, edit_mode);
    end
    tests_run++;
    if (up_q.size() != 0 || dn_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL field_no_strobes: got up %0d down %0d expected 0 0", up_q.size(), dn_q.size());
    end
  endtask

  task automatic test_auto_repeat();
    int t;
    int got;
    int offs[6] = '{0, 20, 28, 36, 44, 52};
    clear_logs();
    hold_btn(2, 56, t);
    wait_cycles(40);
    tests_run++;
    if (dn_q.size() != 6) begin
      tests_failed++;
      $display("[TB] FAIL repeat_count: got %0d pulses expected 6", dn_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      got = (dn_q.size() > i) ? dn_q[i] : -1;
      tests_run++;
      if (got != t + LAT + offs[i]) begin
        tests_failed++;
        $display("[TB] FAIL repeat_pulse_%0d: got edge %0d expected %0d", i, got, t + LAT + offs[i]);
      end
    end
    tests_run++;
    if (up_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL repeat_no_up: got %0d pulses expected 0", up_q.size());
    end
  endtask

  task automatic test_idle_and_both();
    int t;
    int r;
    int got;
    hold_btn(0, 6, t);
    wait_cycles(12);
    tests_run++;
    if (edit_mode !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL both_leave_edit: got %0b expected 0", edit_mode);
    end
    clear_logs();
    hold_btn(1, 30, t);
    wait_cycles(10);
    tests_run++;
    if (up_q.size() != 0 || en_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL idle_up_ignored: got %0d pulses field %0d expected 0 0", up_q.size(), en_count);
    end
    hold_btn(0, 6, t);
    wait_cycles(12);
    clear_logs();
    @(negedge clk);
    btn[1] = 1'b1;
    btn[2] = 1'b1;
    wait_cycles(40);
    tests_run++;
    if (up_q.size() != 0 || dn_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL both_held_silent: got up %0d down %0d expected 0 0", up_q.size(), dn_q.size());
    end
    @(negedge clk);
    btn[2] = 1'b0;
    r = cyc + 1;
    wait_cycles(32);
    tests_run++;
    if (up_q.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL both_release_count: got %0d pulses expected 2", up_q.size());
    end
    got = (up_q.size() > 0) ? up_q[0] : -1;
    tests_run++;
    if (got != r + LAT) begin
      tests_failed++;
      $display("[TB] FAIL both_release_first: got edge %0d expected %0d", got, r + LAT);
    end
    got = (up_q.size() > 1) ? up_q[1] : -1;
    tests_run++;
    if (got != r + LAT + HOLD) begin
      tests_failed++;
      $display("[TB] FAIL both_release_hold: got edge %0d expected %0d", got, r + LAT + HOLD);
    end
    @(negedge clk);
    btn[1] = 1'b0;
    wait_cycles(14);
  endtask

  task automatic test_reset_mid();
    int t;
    int got;
    clear_logs();
    @(negedge clk);
    btn[1] = 1'b1;
    t = cyc + 1;
    wait_cycles(LAT + 25);
    tests_run++;
    got = (up_q.size() > 1) ? up_q[1] : -1;
    if (up_q.size() != 2 || got != t + LAT + HOLD) begin
      tests_failed++;
      $display("[TB] FAIL midreset_before: got %0d pulses second at %0d expected 2 at %0d",
               up_q.size(), got, t + LAT + HOLD);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (en_count !== 4'd0 || edit_mode !== 1'b0 || enUP !== 1'b0 || enDOWN !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got field %0d mode %0b up %0b down %0b expected all 0",
               en_count, edit_mode, enUP, enDOWN);
    end
    reset = 1'b0;
    wait_cycles(40);
    btn[1] = 1'b0;
    wait_cycles(12);
    tests_run++;
    if (up_q.size() != 2 || edit_mode !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_silent: got %0d pulses mode %0b expected 2 0", up_q.size(), edit_mode);
    end
    clear_logs();
    hold_btn(0, 6, t);
    wait_cycles(12);
    hold_btn(1, 6, t);
    wait_cycles(12);
    got = (up_q.size() > 0) ? up_q[0] : -1;
    tests_run++;
    if (up_q.size() != 1 || got != t + LAT) begin
      tests_failed++;
      $display("[TB] FAIL midreset_recover: got %0d pulses first at %0d expected 1 at %0d",
               up_q.size(), got, t + LAT);
    end
  endtask

  task automatic test_exclusive();
    tests_run++;
    if (overlap != 0) begin
      tests_failed++;
      $display("[TB] FAIL strobe_exclusive: got %0d overlapping cycles expected 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_edit_toggle();
    test_glitch_up();
    test_field_nav();
    test_auto_repeat();
    test_idle_and_both();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
